// File: rtl/qam_pkg.sv
// Constants shared by the receive-side demapper and the transmit-side mapper:
// modulation selectors, Gray level codes, bits-per-symbol and serialiser states.
package qam_pkg;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_16QAM = 1'b1;

  // Gray codes for the levels -3A, -A, +A, +3A
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  localparam logic [2:0] BPS_QPSK  = 3'd2;
  localparam logic [2:0] BPS_16QAM = 3'd4;

  typedef enum logic {
    SER_EMPTY  = 1'b0,
    SER_LOADED = 1'b1
  } ser_state_t;

  function automatic logic [2:0] bits_per_symbol(input logic mod_sel);
    return (mod_sel == MOD_16QAM) ? BPS_16QAM : BPS_QPSK;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// Per-axis hard slicer. QPSK returns the decided bit in code[1] (code[0]=0);
// 16-QAM returns the Gray code of the nearest level, saturating out-of-range input.
module qam_slicer
  import qam_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 1048576
) (
  input  logic signed [WIDTH-1:0] value,
  input  logic                    mod_type,
  output logic [1:0]              code
);

  // Thresholds are held two bits wider than the sample so 2A never overflows
  localparam logic signed [WIDTH+1:0] LVL_X   = (WIDTH+2)'(LEVEL);
  localparam logic signed [WIDTH+1:0] THR_POS = {LVL_X[WIDTH:0], 1'b0};
  localparam logic signed [WIDTH+1:0] THR_NEG = -THR_POS;

  logic signed [WIDTH+1:0] value_x;
  logic                    nonneg;

  assign value_x = {{2{value[WIDTH-1]}}, value};
  assign nonneg  = ~value[WIDTH-1];

  always_comb begin
    code = GRAY_M3;
    if (mod_type == MOD_16QAM) begin
      if (value_x >= THR_POS)      code = GRAY_P3;
      else if (nonneg)             code = GRAY_P1;
      else if (value_x >= THR_NEG) code = GRAY_M1;
      else                         code = GRAY_M3;
    end else begin
      code = {nonneg, 1'b0};
    end
  end

endmodule

// File: rtl/qam_demapper.sv
// QPSK/16-QAM hard demapper with parallel output and a bit-tick driven
// serialiser; tracks overrun/underrun and counts accepted symbols.
//
// state      | meaning
// SER_EMPTY  | no unsent bits in the shifter (count = 0)
// SER_LOADED | 1..4 unsent bits pending, MSB of shifter is next out
module qam_demapper
  import qam_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mod_type,
  input  logic                    sym_valid,
  input  logic signed [WIDTH-1:0] symbol_i,
  input  logic signed [WIDTH-1:0] symbol_q,
  input  logic                    bit_tick,
  output logic [3:0]              par_out,
  output logic                    par_valid,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    overrun,
  output logic                    underrun,
  output logic [15:0]             sym_count
);

  logic [1:0] code_i, code_q;
  logic [3:0] group;
  logic [2:0] group_bits;

  qam_slicer #(.WIDTH(WIDTH), .LEVEL(LEVEL)) u_slice_i (
    .value    (symbol_i),
    .mod_type (mod_type),
    .code     (code_i)
  );

  qam_slicer #(.WIDTH(WIDTH), .LEVEL(LEVEL)) u_slice_q (
    .value    (symbol_q),
    .mod_type (mod_type),
    .code     (code_q)
  );

  assign group      = (mod_type == MOD_16QAM) ? {code_i, code_q}
                                              : {code_i[1], code_q[1], 2'b00};
  assign group_bits = bits_per_symbol(mod_type);

  ser_state_t state, state_nx;
  logic [3:0] shifter, shifter_nx, shift_mid;
  logic [2:0] count, count_nx, count_mid;
  logic       serve, overrun_hit, underrun_hit;

  // A tick is always served from the old contents before any same-cycle load
  always_comb begin
    serve        = bit_tick && (state == SER_LOADED);
    underrun_hit = bit_tick && (state == SER_EMPTY);
    shift_mid    = serve ? {shifter[2:0], 1'b0} : shifter;
    count_mid    = serve ? (count - 3'd1) : count;
    shifter_nx   = shift_mid;
    count_nx     = count_mid;
    overrun_hit  = 1'b0;
    if (sym_valid) begin
      shifter_nx  = group;
      count_nx    = group_bits;
      overrun_hit = (count_mid != 3'd0);
    end
    state_nx = (count_nx != 3'd0) ? SER_LOADED : SER_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SER_EMPTY;
      shifter <= 4'd0;
      count   <= 3'd0;
    end else begin
      state   <= state_nx;
      shifter <= shifter_nx;
      count   <= count_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_out   <= 4'd0;
      par_valid <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      sym_count <= 16'd0;
    end else begin
      par_valid <= sym_valid;
      bit_valid <= serve;
      if (sym_valid) begin
        par_out   <= group;
        sym_count <= sym_count + 16'd1;
      end
      if (serve)        bit_out  <= shifter[3];
      if (overrun_hit)  overrun  <= 1'b1;
      if (underrun_hit) underrun <= 1'b1;
    end
  end

endmodule
